fp_multiplier_param: RTL and testbench

- Parametrised sequential IEEE 754 floating-point multiplier. Successor to the fixed single-precision multiplier.
- Format is set by EXP_W/MAN_W (half, single, or custom). Uses a radix-2 shift-add mantissa datapath.
- Adds round-to-nearest-even rounding, special-operand handling and exception flags.
- Sits behind the FPU issue logic with the same start/valid/busy handshake as the existing multiplier.

---
 rtl/fp_multiplier_param.sv | 255 +++++++++++++++++++++++++
 tb/tb_fp_multiplier_param.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_multiplier_param.sv
// Sequential IEEE 754 multiplier with a parametrised format (EXP_W/MAN_W) and a radix-2 shift-add significand datapath.
// Optional build macro FP_MUL_ROUND_MODE_EN adds an rm port (RNE/RTZ/RUP/RDN); without it the unit rounds to nearest-even.
module fp_multiplier_param #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [EXP_W+MAN_W:0]   rs1,
    input  logic [EXP_W+MAN_W:0]   rs2,
    input  logic                   start,
`ifdef FP_MUL_ROUND_MODE_EN
    input  logic [1:0]             rm,
`endif
    output logic [EXP_W+MAN_W:0]   result,
    output logic                   valid,
    output logic                   busy,
    output logic [3:0]             flags,
    output logic [2:0]             state_dbg
);

    // Handshake: start is accepted only when busy is low (IDLE); operands are captured on that
    // edge. valid pulses for exactly one cycle; result/flags then stay put until the next completion.

    localparam int W      = 1 + EXP_W + MAN_W;
    localparam int SIG_W  = MAN_W + 1;
    localparam int PROD_W = 2 * SIG_W;
    localparam int EW     = EXP_W + 2;
    localparam int CNT_W  = $clog2(MAN_W + 1);

    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic [EW-1:0]    BIAS     = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic [EW-1:0]    EXP_MAX  = EW'((1 << EXP_W) - 1);
    localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_UNPACK = 3'd1,
        S_MULT   = 3'd2,
        S_NORM   = 3'd3,
        S_ROUND  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t state, next_state;

    logic [W-1:0]      op_a, op_b;
    logic              sign_q;
    logic [EW-1:0]     prod_exp;
    logic [PROD_W-1:0] mcand;
    logic [SIG_W-1:0]  mplier;
    logic [PROD_W-1:0] acc;
    logic [CNT_W-1:0]  cnt;
    logic              sticky_q;
    logic              spec_hold;
`ifdef FP_MUL_ROUND_MODE_EN
    logic [1:0]        rm_q;
`endif

    // Operand classification (subnormals count as zero)
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan, special;

    assign ea     = op_a[W-2 -: EXP_W];
    assign eb     = op_b[W-2 -: EXP_W];
    assign fa     = op_a[MAN_W-1:0];
    assign fb     = op_b[MAN_W-1:0];
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_inf  = (ea == EXP_ONES) && (fa == '0);
    assign b_inf  = (eb == EXP_ONES) && (fb == '0);
    assign a_nan  = (ea == EXP_ONES) && (fa != '0);
    assign b_nan  = (eb == EXP_ONES) && (fb != '0);
    assign a_snan = a_nan && !fa[MAN_W-1];
    assign b_snan = b_nan && !fb[MAN_W-1];
    assign special = a_zero || b_zero || a_inf || b_inf || a_nan || b_nan;

    logic          prod_sign;
    logic [EW-1:0] exp_sum;

    assign prod_sign = op_a[W-1] ^ op_b[W-1];
    assign exp_sum   = {2'b00, ea} + {2'b00, eb} - BIAS;

    logic [W-1:0] spec_res;
    logic [3:0]   spec_flg;

    always_comb begin
        spec_res = '0;
        spec_flg = '0;
        if (a_nan || b_nan) begin
            spec_res    = QNAN;
            spec_flg[3] = a_snan || b_snan;
        end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
            spec_res    = QNAN;
            spec_flg[3] = 1'b1;
        end else if (a_inf || b_inf) begin
            spec_res = {prod_sign, EXP_ONES, {MAN_W{1'b0}}};
        end else begin
            spec_res = {prod_sign, {(W-1){1'b0}}};
        end
    end

    // Rounding on the normalised product: leading one sits at bit 2*MAN_W
    logic             lsb_bit, grd_bit, stk_bit, rnd_up, to_inf;
    logic [SIG_W:0]   mant_sum;
    logic [EW-1:0]    exp_f;
    logic             ovf, unf;
    logic [W-1:0]     rnd_res;
    logic [3:0]       rnd_flg;

    assign lsb_bit  = acc[MAN_W];
    assign grd_bit  = acc[MAN_W-1];
    assign stk_bit  = sticky_q || (|acc[MAN_W-2:0]);

    always_comb begin
        rnd_up = grd_bit && (stk_bit || lsb_bit);
        to_inf = 1'b1;
`ifdef FP_MUL_ROUND_MODE_EN
        case (rm_q)
            2'b01: begin
                rnd_up = 1'b0;
                to_inf = 1'b0;
            end
            2'b10: begin
                rnd_up = (grd_bit || stk_bit) && !sign_q;
                to_inf = !sign_q;
            end
            2'b11: begin
                rnd_up = (grd_bit || stk_bit) && sign_q;
                to_inf = sign_q;
            end
            default: ;
        endcase
`endif
    end

    // A carry out leaves the low MAN_W bits all zero, so the fraction field needs no shift
    assign mant_sum = {1'b0, acc[2*MAN_W:MAN_W]} + (SIG_W+1)'(rnd_up);
    assign exp_f    = prod_exp + EW'(mant_sum[SIG_W]);
    assign ovf      = $signed(exp_f) >= $signed(EXP_MAX);
    assign unf      = exp_f[EW-1] || (exp_f == '0);

    always_comb begin
        rnd_res = '0;
        rnd_flg = '0;
        if (ovf) begin
            rnd_res = to_inf ? {sign_q, EXP_ONES, {MAN_W{1'b0}}}
                             : {sign_q, EXP_ONES - EXP_W'(1), {MAN_W{1'b1}}};
            rnd_flg = 4'b0101;
        end else if (unf) begin
            rnd_res = {sign_q, {(W-1){1'b0}}};
            rnd_flg = 4'b0011;
        end else begin
            rnd_res = {sign_q, exp_f[EXP_W-1:0], mant_sum[MAN_W-1:0]};
            rnd_flg = {3'b000, grd_bit || stk_bit};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= next_state;
    end

    // Special operands wait one extra UNPACK cycle so their latency is a fixed two edges
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (start) next_state = S_UNPACK;
            S_UNPACK: begin
                if (!special)       next_state = S_MULT;
                else if (spec_hold) next_state = S_DONE;
            end
            S_MULT:   if (cnt == CNT_W'(MAN_W)) next_state = S_NORM;
            S_NORM:   next_state = S_ROUND;
            S_ROUND:  next_state = S_DONE;
            S_DONE:   next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    assign valid     = (state == S_DONE);
    assign busy      = (state != S_IDLE);
    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_a      <= '0;
            op_b      <= '0;
            sign_q    <= 1'b0;
            prod_exp  <= '0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            cnt       <= '0;
            sticky_q  <= 1'b0;
            spec_hold <= 1'b0;
            result    <= '0;
            flags     <= '0;
`ifdef FP_MUL_ROUND_MODE_EN
            rm_q      <= 2'b00;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_a      <= rs1;
                        op_b      <= rs2;
                        spec_hold <= 1'b0;
`ifdef FP_MUL_ROUND_MODE_EN
                        rm_q      <= rm;
`endif
                    end
                end
                S_UNPACK: begin
                    sign_q <= prod_sign;
                    if (special) begin
                        spec_hold <= 1'b1;
                        if (spec_hold) begin
                            result <= spec_res;
                            flags  <= spec_flg;
                        end
                    end else begin
                        mcand    <= PROD_W'({1'b1, fa});
                        mplier   <= {1'b1, fb};
                        acc      <= '0;
                        cnt      <= '0;
                        prod_exp <= exp_sum;
                    end
                end
                S_MULT: begin
                    if (mplier[0]) acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CNT_W'(1);
                end
                S_NORM: begin
                    if (acc[PROD_W-1]) begin
                        acc      <= acc >> 1;
                        sticky_q <= acc[0];
                        prod_exp <= prod_exp + EW'(1);
                    end else begin
                        sticky_q <= 1'b0;
                    end
                end
                S_ROUND: begin
                    result <= rnd_res;
                    flags  <= rnd_flg;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_multiplier_param.sv
// Bench for fp_multiplier_param: a single-precision and a half-precision instance sharing clock and reset.
// Build with FP_MUL_ROUND_MODE_EN to also exercise the rm port.
module tb_fp_multiplier_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start, h_start;
    logic [31:0] rs1, rs2, result;
    logic [15:0] h_rs1, h_rs2, h_result;
    logic        valid, busy, h_valid, h_busy;
    logic [3:0]  flags, h_flags;
    logic [2:0]  state_dbg, h_state_dbg;
`ifdef FP_MUL_ROUND_MODE_EN
    logic [1:0]  rm, h_rm;
`endif

    fp_multiplier_param #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .start(start),
`ifdef FP_MUL_ROUND_MODE_EN
        .rm(rm),
`endif
        .result(result), .valid(valid), .busy(busy), .flags(flags), .state_dbg(state_dbg)
    );

    fp_multiplier_param #(.EXP_W(5), .MAN_W(10)) dut_h (
        .clk(clk), .rst(rst), .rs1(h_rs1), .rs2(h_rs2), .start(h_start),
`ifdef FP_MUL_ROUND_MODE_EN
        .rm(h_rm),
`endif
        .result(h_result), .valid(h_valid), .busy(h_busy), .flags(h_flags), .state_dbg(h_state_dbg)
    );

    int          total = 0;
    int          bad   = 0;
    logic [35:0] exp_q[$];
    logic [1:0]  cur_mode = 2'b00;

    // Reference: exact product in double precision, then RNE down to single
    function automatic logic [35:0] model_mul(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] da, db, pb;
        real         p;
        logic [23:0] fr;
        logic        g, s, up;
        int          e;
        da = {a[31], 11'(a[30:23]) + 11'd896, a[22:0], 29'b0};
        db = {b[31], 11'(b[30:23]) + 11'd896, b[22:0], 29'b0};
        p  = $bitstoreal(da) * $bitstoreal(db);
        pb = $realtobits(p);
        g  = pb[28];
        s  = |pb[27:0];
        up = g && (s || pb[29]);
        fr = {1'b0, pb[51:29]} + 24'(up);
        e  = int'(pb[62:52]) - 896 + int'(fr[23]);
        return {pb[63], 8'(e), fr[22:0], 3'b000, g || s};
    endfunction

    task automatic issue(input bit half, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] mode, input logic [31:0] e_res, input logic [3:0] e_flg);
        @(negedge clk);
        if (half) begin
            h_rs1 = a[15:0]; h_rs2 = b[15:0]; h_start = 1'b1;
        end else begin
            rs1 = a; rs2 = b; start = 1'b1;
        end
        cur_mode = mode;
`ifdef FP_MUL_ROUND_MODE_EN
        if (half) h_rm = mode; else rm = mode;
`endif
        exp_q.push_back({e_res, e_flg});
        @(negedge clk);
        start = 1'b0;
        h_start = 1'b0;
    endtask

    // Returns the number of edges after the start-sampling edge at which valid was seen (-1 on timeout)
    task automatic wait_valid(input bit half, input int poke_at, output int lat, output bit busy_all);
        lat = -1;
        busy_all = 1'b1;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (half ? h_valid : valid) begin
                lat = k;
                break;
            end
            if (!(half ? h_busy : busy)) busy_all = 1'b0;
            if (k == poke_at) begin
                rs1 = 32'h3F800000; rs2 = 32'h3F800000; start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({result, flags, valid, busy, state_dbg} !== 41'h0) begin
            bad++;
            $display("FAIL reset_state: got res=%h flg=%b v=%b b=%b st=%0d want all zero", result, flags, valid, busy, state_dbg);
        end
        total++;
        if ({h_result, h_flags, h_valid, h_busy} !== 22'h0) begin
            bad++;
            $display("FAIL reset_state_half: got res=%h flg=%b v=%b b=%b want all zero", h_result, h_flags, h_valid, h_busy);
        end
        rst = 1'b1;
    endtask

    task automatic test_basic();
        int lat; bit busy_all; logic [35:0] want;
        issue(0, 32'h40400000, 32'h40000000, 2'b00, 32'h40C00000, 4'b0000);
        wait_valid(0, 0, lat, busy_all);
        want = exp_q.pop_front();
        total++;
        if (lat !== 27) begin bad++; $display("FAIL basic_latency: got %0d want 27", lat); end
        total++;
        if (busy_all !== 1'b1) begin bad++; $display("FAIL basic_busy: busy dropped during operation, want high"); end
        total++;
        if ({result, flags} !== want) begin
            bad++; $display("FAIL basic_result: got %h/%b want %h/%b", result, flags, want[35:4], want[3:0]);
        end
        @(negedge clk);
        total++;
        if ({valid, busy} !== 2'b00) begin bad++; $display("FAIL basic_pulse: got valid=%b busy=%b want 0 0", valid, busy); end
    endtask

    task automatic test_rounding();
        logic [31:0] ta [0:4] = '{32'h3F800001, 32'h3FC00000, 32'h3FC00000, 32'h3FFFFFFF, 32'h3F800001};
        logic [31:0] tb [0:4] = '{32'h3F800001, 32'h3F800001, 32'h3F800003, 32'h3F800001, 32'h3F800001};
        logic [1:0]  tm [0:4] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b10};
        logic [31:0] tr [0:4] = '{32'h3F800002, 32'h3FC00002, 32'h3FC00004, 32'h40000000, 32'h3F800003};
        int n; int lat; bit busy_all; logic [35:0] want;
`ifdef FP_MUL_ROUND_MODE_EN
        n = 5;
`else
        n = 4;
`endif
        for (int i = 0; i < n; i++) begin
            issue(0, ta[i], tb[i], tm[i], tr[i], 4'b0001);
            wait_valid(0, 0, lat, busy_all);
            want = exp_q.pop_front();
            total++;
            if ({result, flags} !== want || lat !== 27) begin
                bad++;
                $display("FAIL round[%0d] mode=%0d: got %h/%b lat=%0d want %h/%b lat=27", i, cur_mode, result, flags, lat, want[35:4], want[3:0]);
            end
        end
    endtask

    task automatic test_specials();
        logic [31:0] ta [0:6] = '{32'h7F800000, 32'hFF800000, 32'h7F800001, 32'h7FC00000, 32'h80000000, 32'h00000001, 32'hFF800000};
        logic [31:0] tb [0:6] = '{32'h00000000, 32'h40000000, 32'h3F800000, 32'h3F800000, 32'h40400000, 32'hBF800000, 32'hFF800000};
        logic [31:0] tr [0:6] = '{32'h7FC00000, 32'hFF800000, 32'h7FC00000, 32'h7FC00000, 32'h80000000, 32'h80000000, 32'h7F800000};
        logic [3:0]  tf [0:6] = '{4'b1000, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        int lat; bit busy_all; logic [35:0] want;
        for (int i = 0; i < 7; i++) begin
            issue(0, ta[i], tb[i], 2'b00, tr[i], tf[i]);
            wait_valid(0, 0, lat, busy_all);
            want = exp_q.pop_front();
            total++;
            if (lat !== 2) begin bad++; $display("FAIL special_latency[%0d]: got %0d want 2", i, lat); end
            total++;
            if ({result, flags} !== want) begin
                bad++; $display("FAIL special[%0d]: got %h/%b want %h/%b", i, result, flags, want[35:4], want[3:0]);
            end
        end
    endtask

    task automatic test_range();
        logic [31:0] ta [0:7] = '{32'h7F7FFFFF, 32'hFF7FFFFF, 32'h00800000, 32'h80800000,
                                  32'h7F7FFFFF, 32'h7F7FFFFF, 32'hFF7FFFFF, 32'hFF7FFFFF};
        logic [31:0] tb [0:7] = '{32'h40000000, 32'h40000000, 32'h3F000000, 32'h3F000000,
                                  32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000};
        logic [1:0]  tm [0:7] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b11, 2'b10, 2'b11};
        logic [31:0] tr [0:7] = '{32'h7F800000, 32'hFF800000, 32'h00000000, 32'h80000000,
                                  32'h7F7FFFFF, 32'h7F7FFFFF, 32'hFF7FFFFF, 32'hFF800000};
        logic [3:0]  tf [0:7] = '{4'b0101, 4'b0101, 4'b0011, 4'b0011, 4'b0101, 4'b0101, 4'b0101, 4'b0101};
        int n; int lat; bit busy_all; logic [35:0] want;
`ifdef FP_MUL_ROUND_MODE_EN
        n = 8;
`else
        n = 4;
`endif
        for (int i = 0; i < n; i++) begin
            issue(0, ta[i], tb[i], tm[i], tr[i], tf[i]);
            wait_valid(0, 0, lat, busy_all);
            want = exp_q.pop_front();
            total++;
            if ({result, flags} !== want || lat !== 27) begin
                bad++;
                $display("FAIL range[%0d] mode=%0d: got %h/%b lat=%0d want %h/%b lat=27", i, cur_mode, result, flags, lat, want[35:4], want[3:0]);
            end
        end
    endtask

    task automatic test_start_ignored();
        int lat; bit busy_all; logic [35:0] want;
        issue(0, 32'h40400000, 32'h40000000, 2'b00, 32'h40C00000, 4'b0000);
        wait_valid(0, 6, lat, busy_all);
        want = exp_q.pop_front();
        total++;
        if ({result, flags} !== want || lat !== 27) begin
            bad++; $display("FAIL start_mid_mult: got %h/%b lat=%0d want %h/%b lat=27", result, flags, lat, want[35:4], want[3:0]);
        end
        // start while in DONE must not begin a new operation
        rs1 = 32'h3F800000; rs2 = 32'h3F800000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({valid, busy} !== 2'b00) begin bad++; $display("FAIL start_in_done: got valid=%b busy=%b want 0 0", valid, busy); end
    endtask

    task automatic test_reset_mid();
        int lat; bit busy_all; bit seen; logic [35:0] want;
        issue(0, 32'h40400000, 32'h40400000, 2'b00, 32'h41100000, 4'b0000);
        repeat (8) @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if ({busy, valid, result, flags, state_dbg} !== 41'h0) begin
            bad++; $display("FAIL reset_mid: got busy=%b valid=%b res=%h flg=%b st=%0d want all zero", busy, valid, result, flags, state_dbg);
        end
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (valid) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin bad++; $display("FAIL reset_abort: got a valid pulse after abort, want none"); end
        issue(0, 32'h40400000, 32'h40400000, 2'b00, 32'h41100000, 4'b0000);
        wait_valid(0, 0, lat, busy_all);
        want = exp_q.pop_front();
        total++;
        if ({result, flags} !== want || lat !== 27) begin
            bad++; $display("FAIL reset_recover: got %h/%b lat=%0d want %h/%b lat=27", result, flags, lat, want[35:4], want[3:0]);
        end
    endtask

    task automatic test_half();
        logic [15:0] ta [0:3] = '{16'h3C00, 16'h7BFF, 16'h3E00, 16'h7C00};
        logic [15:0] tb [0:3] = '{16'h4000, 16'h4000, 16'h3E00, 16'h0000};
        logic [15:0] tr [0:3] = '{16'h4000, 16'h7C00, 16'h4080, 16'h7E00};
        logic [3:0]  tf [0:3] = '{4'b0000, 4'b0101, 4'b0000, 4'b1000};
        int          tl [0:3] = '{14, 14, 14, 2};
        int lat; bit busy_all; logic [35:0] want;
        for (int i = 0; i < 4; i++) begin
            issue(1, {16'h0, ta[i]}, {16'h0, tb[i]}, 2'b00, {16'h0, tr[i]}, tf[i]);
            wait_valid(1, 0, lat, busy_all);
            want = exp_q.pop_front();
            total++;
            if (lat !== tl[i]) begin bad++; $display("FAIL half_latency[%0d]: got %0d want %0d", i, lat, tl[i]); end
            total++;
            if ({16'h0, h_result, h_flags} !== want) begin
                bad++; $display("FAIL half[%0d]: got %h/%b want %h/%b", i, h_result, h_flags, want[19:4], want[3:0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b;
        logic [35:0] m, want;
        int lat; bit busy_all;
        for (int k = 0; k < 12; k++) begin
            a = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 154)), 23'($urandom)};
            b = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 154)),
                 (k % 2 == 0) ? 23'($urandom) : 23'($urandom_range(0, 7)) << 20};
            m = model_mul(a, b);
            issue(0, a, b, 2'b00, m[35:4], m[3:0]);
            wait_valid(0, 0, lat, busy_all);
            want = exp_q.pop_front();
            total++;
            if ({result, flags} !== want || lat !== 27) begin
                bad++;
                $display("FAIL b2b[%0d] %h*%h: got %h/%b lat=%0d want %h/%b lat=27", k, a, b, result, flags, lat, want[35:4], want[3:0]);
            end
        end
    endtask

    initial begin
        start = 1'b0; h_start = 1'b0;
        rs1 = '0; rs2 = '0; h_rs1 = '0; h_rs2 = '0;
`ifdef FP_MUL_ROUND_MODE_EN
        rm = 2'b00; h_rm = 2'b00;
`endif
        test_reset();
        test_basic();
        test_rounding();
        test_specials();
        test_range();
        test_start_ignored();
        test_reset_mid();
        test_half();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
